// File: rtl/h80_clkctl.sv
// h80 CPU clock controller: divided, haltable, single/burst-steppable CPU clock
// plus a debounced push-button (short press = step, long press = toggle autorun).
module h80_clkctl #(
    parameter int SYSCLK_FREQ     = 27000000,
    parameter int TICK_CYCLES     = SYSCLK_FREQ / 1000,
    parameter int DEBOUNCE_TICKS  = 100,
    parameter int LONGPRESS_TICKS = 2000,
    parameter int DIV_WIDTH       = 5,
    parameter int STEP_WIDTH      = 8,
    parameter bit AUTORUN_INIT    = 1'b1
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  btn,
    input  logic [DIV_WIDTH-1:0]  div_sel,
    input  logic                  halt,
    input  logic                  step_req,
    input  logic [STEP_WIDTH-1:0] step_count,
    output logic                  cpu_clk,
    output logic                  cpu_clk_rise,
    output logic                  autorun,
    output logic                  step_busy,
    output logic                  short_evt,
    output logic                  long_evt,
    output logic [1:0]            clk_state_o,
    output logic [1:0]            btn_state_o
);
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int BW = $clog2(LONGPRESS_TICKS + 1);
    localparam int HW = 2 ** DIV_WIDTH;

    typedef enum logic [1:0] {B_IDLE = 2'd0, B_PRESS = 2'd1, B_HELD = 2'd2, B_REL = 2'd3} btn_state_e;
    typedef enum logic [1:0] {C_IDLE = 2'd0, C_HIGH = 2'd1, C_LOW = 2'd2} clk_state_e;

    logic                  btn_meta_q, btn_sync_q;
    logic [TW-1:0]         tick_cnt_q;
    logic                  tick;
    btn_state_e            btn_state_q;
    logic [BW-1:0]         btn_cnt_q, btn_cnt_d, long_thr;
    logic                  first_tick_q, po_q;
    logic                  short_evt_q, long_evt_q, autorun_q, long_fire;
    clk_state_e            clk_state_q;
    logic [HW-1:0]         hp_cnt_q;
    logic [DIV_WIDTH-1:0]  div_lat_q;
    logic                  cpu_clk_q, cpu_clk_rise_q;
    logic [STEP_WIDTH-1:0] step_rem_q;
    logic                  go, enter_high;

    function automatic logic [HW-1:0] half_max(input logic [DIV_WIDTH-1:0] d);
        return (HW'(1) << d) - HW'(1);
    endfunction

    always_ff @(posedge sysclk) begin
        if (reset) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            btn_meta_q <= btn;
            btn_sync_q <= btn_meta_q;
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
        end
    end

    assign tick      = (tick_cnt_q == TW'(TICK_CYCLES - 1));
    assign btn_cnt_d = btn_cnt_q + BW'(1);
    // A press already held at the first tick after reset gets the short threshold.
    assign long_thr  = po_q ? BW'(DEBOUNCE_TICKS) : BW'(LONGPRESS_TICKS);
    assign long_fire = tick && (btn_state_q == B_PRESS) && btn_sync_q && (btn_cnt_d == long_thr);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            btn_state_q  <= B_IDLE;
            btn_cnt_q    <= '0;
            short_evt_q  <= 1'b0;
            long_evt_q   <= 1'b0;
            autorun_q    <= AUTORUN_INIT;
            first_tick_q <= 1'b1;
            po_q         <= 1'b0;
        end else begin
            short_evt_q <= 1'b0;
            long_evt_q  <= 1'b0;
            if (tick) begin
                first_tick_q <= 1'b0;
                case (btn_state_q)
                    B_IDLE: if (btn_sync_q) begin
                        btn_state_q <= B_PRESS;
                        btn_cnt_q   <= '0;
                        po_q        <= first_tick_q;
                    end
                    B_PRESS: begin
                        if (!btn_sync_q) begin
                            po_q      <= 1'b0;
                            btn_cnt_q <= '0;
                            if (btn_cnt_q < BW'(DEBOUNCE_TICKS)) begin
                                btn_state_q <= B_IDLE;
                            end else begin
                                short_evt_q <= 1'b1;
                                btn_state_q <= B_REL;
                            end
                        end else if (long_fire) begin
                            long_evt_q  <= 1'b1;
                            autorun_q   <= ~autorun_q;
                            po_q        <= 1'b0;
                            btn_cnt_q   <= '0;
                            btn_state_q <= B_HELD;
                        end else begin
                            btn_cnt_q <= btn_cnt_d;
                        end
                    end
                    B_HELD: if (!btn_sync_q) begin
                        btn_state_q <= B_REL;
                        btn_cnt_q   <= '0;
                    end
                    default: begin
                        if (btn_sync_q) begin
                            btn_cnt_q <= '0;
                        end else if (btn_cnt_d == BW'(DEBOUNCE_TICKS)) begin
                            btn_cnt_q   <= '0;
                            btn_state_q <= B_IDLE;
                        end else begin
                            btn_cnt_q <= btn_cnt_d;
                        end
                    end
                endcase
            end
        end
    end

    // go is only consulted at period boundaries, so a started period always completes.
    assign go         = autorun_q ? ~halt : (step_rem_q != '0);
    assign enter_high = go && ((clk_state_q == C_IDLE) ||
                               ((clk_state_q == C_LOW) && (hp_cnt_q == '0)));

    always_ff @(posedge sysclk) begin
        if (reset) begin
            clk_state_q    <= C_IDLE;
            cpu_clk_q      <= 1'b0;
            cpu_clk_rise_q <= 1'b0;
            hp_cnt_q       <= '0;
            div_lat_q      <= '0;
        end else begin
            cpu_clk_rise_q <= 1'b0;
            if (enter_high) begin
                clk_state_q    <= C_HIGH;
                cpu_clk_q      <= 1'b1;
                cpu_clk_rise_q <= 1'b1;
                div_lat_q      <= div_sel;
                hp_cnt_q       <= half_max(div_sel);
            end else begin
                case (clk_state_q)
                    C_HIGH: if (hp_cnt_q == '0) begin
                        clk_state_q <= C_LOW;
                        cpu_clk_q   <= 1'b0;
                        hp_cnt_q    <= half_max(div_lat_q);
                    end else begin
                        hp_cnt_q <= hp_cnt_q - HW'(1);
                    end
                    C_LOW: if (hp_cnt_q == '0) begin
                        clk_state_q <= C_IDLE;
                    end else begin
                        hp_cnt_q <= hp_cnt_q - HW'(1);
                    end
                    default: begin
                        clk_state_q <= C_IDLE;
                        cpu_clk_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset || long_fire) begin
            step_rem_q <= '0;
        end else if (step_rem_q == '0) begin
            if (step_req) begin
                step_rem_q <= (step_count == '0) ? STEP_WIDTH'(1) : step_count;
            end else if (short_evt_q && !autorun_q) begin
                step_rem_q <= STEP_WIDTH'(1);
            end
        end else if (enter_high && !autorun_q) begin
            step_rem_q <= step_rem_q - STEP_WIDTH'(1);
        end
    end

    assign cpu_clk      = cpu_clk_q;
    assign cpu_clk_rise = cpu_clk_rise_q;
    assign autorun      = autorun_q;
    assign step_busy    = (step_rem_q != '0);
    assign short_evt    = short_evt_q;
    assign long_evt     = long_evt_q;
    assign clk_state_o  = clk_state_q;
    assign btn_state_o  = btn_state_q;
endmodule

// File: tb/tb_h80_clkctl.sv
// Directed bench for h80_clkctl with small tick/debounce parameters.
module tb_h80_clkctl;
    localparam int DIV_WIDTH  = 5;
    localparam int STEP_WIDTH = 8;

    logic                  sysclk;
    logic                  reset, btn, halt, step_req;
    logic [DIV_WIDTH-1:0]  div_sel;
    logic [STEP_WIDTH-1:0] step_count;
    logic                  cpu_clk, cpu_clk_rise, autorun, step_busy, short_evt, long_evt;
    logic [1:0]            clk_state, btn_state;

    int checks = 0;
    int passes = 0;

    h80_clkctl #(
        .SYSCLK_FREQ(4000), .TICK_CYCLES(4), .DEBOUNCE_TICKS(3), .LONGPRESS_TICKS(10),
        .DIV_WIDTH(DIV_WIDTH), .STEP_WIDTH(STEP_WIDTH), .AUTORUN_INIT(1'b1)
    ) dut (
        .sysclk(sysclk), .reset(reset), .btn(btn), .div_sel(div_sel), .halt(halt),
        .step_req(step_req), .step_count(step_count), .cpu_clk(cpu_clk),
        .cpu_clk_rise(cpu_clk_rise), .autorun(autorun), .step_busy(step_busy),
        .short_evt(short_evt), .long_evt(long_evt),
        .clk_state_o(clk_state), .btn_state_o(btn_state)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic wait_idle(input int max_cyc, input bit need_clk, input string name);
        int n = 0;
        while (!(btn_state == 2'd0 && (!need_clk || clk_state == 2'd0)) && n < max_cyc) begin
            @(negedge sysclk);
            n++;
        end
        checks++;
        if (btn_state == 2'd0 && (!need_clk || clk_state == 2'd0)) passes++;
        else $display("FAIL %s: still busy after %0d cycles (btn_state=%0d clk_state=%0d)", name, n, btn_state, clk_state);
    endtask

    task automatic press(input int hold, input int window, output int n_short, output int n_long, output int n_rise);
        n_short = 0; n_long = 0; n_rise = 0;
        for (int c = 0; c < window; c++) begin
            btn = (c < hold);
            @(negedge sysclk);
            n_short += int'(short_evt);
            n_long  += int'(long_evt);
            n_rise  += int'(cpu_clk_rise);
        end
        btn = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; btn = 1'b0; halt = 1'b0; step_req = 1'b0; step_count = '0; div_sel = 5'd2;
        repeat (3) @(negedge sysclk);
        checks++; if (cpu_clk !== 1'b0) $display("FAIL rst_clk: got %b want 0", cpu_clk); else passes++;
        checks++; if (cpu_clk_rise !== 1'b0) $display("FAIL rst_rise: got %b want 0", cpu_clk_rise); else passes++;
        checks++; if (step_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", step_busy); else passes++;
        checks++; if (short_evt !== 1'b0) $display("FAIL rst_short: got %b want 0", short_evt); else passes++;
        checks++; if (long_evt !== 1'b0) $display("FAIL rst_long: got %b want 0", long_evt); else passes++;
        checks++; if (autorun !== 1'b1) $display("FAIL rst_autorun: got %b want 1", autorun); else passes++;
    endtask

    task automatic test_autorun;
        reset = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge sysclk);
            checks++;
            if (cpu_clk !== ((k % 8) < 4)) $display("FAIL auto_clk k=%0d: got %b want %b", k, cpu_clk, (k % 8) < 4);
            else passes++;
            checks++;
            if (cpu_clk_rise !== ((k % 8) == 0)) $display("FAIL auto_rise k=%0d: got %b want %b", k, cpu_clk_rise, (k % 8) == 0);
            else passes++;
        end
    endtask

    task automatic test_halt;
        int n = 0;
        div_sel = 5'd3;
        do begin @(negedge sysclk); n++; end while (!cpu_clk_rise && n < 16);
        checks++; if (!cpu_clk_rise) $display("FAIL halt_sync: no rise within %0d cycles", n); else passes++;
        for (int k = 1; k < 28; k++) begin
            @(negedge sysclk);
            checks++;
            if (cpu_clk !== (k < 8) || cpu_clk_rise !== 1'b0)
                $display("FAIL halt_k%0d: clk=%b rise=%b want clk=%b rise=0", k, cpu_clk, cpu_clk_rise, k < 8);
            else passes++;
            if (k == 2) halt = 1'b1;
        end
        halt = 1'b0;
        @(negedge sysclk);
        checks++;
        if (cpu_clk !== 1'b1 || cpu_clk_rise !== 1'b1) $display("FAIL halt_resume: clk=%b rise=%b want 1/1", cpu_clk, cpu_clk_rise);
        else passes++;
    endtask

    task automatic test_power_on_override;
        int lat = 0;
        bit seen = 1'b0;
        @(negedge sysclk);
        reset = 1'b1; btn = 1'b1; div_sel = 5'd1; halt = 1'b0; step_req = 1'b0;
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge sysclk);
            lat++;
            if (long_evt) seen = 1'b1;
        end
        checks++; if (!seen || lat > 24) $display("FAIL po_long: seen=%b after %0d cycles want seen=1 within 24", seen, lat); else passes++;
        checks++; if (autorun !== 1'b0) $display("FAIL po_autorun: got %b want 0", autorun); else passes++;
        btn = 1'b0;
        wait_idle(200, 1'b1, "po_idle");
        checks++; if (cpu_clk !== 1'b0) $display("FAIL po_clk: got %b want 0", cpu_clk); else passes++;
    endtask

    task automatic test_short_press;
        int ns, nl, nr;
        press(24, 80, ns, nl, nr);
        checks++; if (ns != 1) $display("FAIL short_evt_cnt: got %0d want 1", ns); else passes++;
        checks++; if (nl != 0) $display("FAIL short_long_cnt: got %0d want 0", nl); else passes++;
        checks++; if (nr != 1) $display("FAIL short_rise_cnt: got %0d want 1", nr); else passes++;
        wait_idle(200, 1'b1, "short_idle");
        press(4, 60, ns, nl, nr);
        checks++; if (ns != 0 || nl != 0) $display("FAIL bounce_evt: short=%0d long=%0d want 0/0", ns, nl); else passes++;
        checks++; if (nr != 0) $display("FAIL bounce_rise: got %0d want 0", nr); else passes++;
        wait_idle(200, 1'b1, "bounce_idle");
    endtask

    task automatic test_long_press;
        int ns, nl, nr;
        int n_high = 0;
        press(48, 100, ns, nl, nr);
        checks++; if (nl != 1 || ns != 0) $display("FAIL long1_evt: long=%0d short=%0d want 1/0", nl, ns); else passes++;
        checks++; if (autorun !== 1'b1) $display("FAIL long1_autorun: got %b want 1", autorun); else passes++;
        checks++; if (nr == 0) $display("FAIL long1_rise: got %0d want >0", nr); else passes++;
        wait_idle(200, 1'b0, "long1_idle");
        press(48, 100, ns, nl, nr);
        checks++; if (nl != 1 || ns != 0) $display("FAIL long2_evt: long=%0d short=%0d want 1/0", nl, ns); else passes++;
        checks++; if (autorun !== 1'b0) $display("FAIL long2_autorun: got %b want 0", autorun); else passes++;
        wait_idle(200, 1'b1, "long2_idle");
        nr = 0;
        repeat (40) begin
            @(negedge sysclk);
            nr += int'(cpu_clk_rise);
            n_high += int'(cpu_clk);
        end
        checks++; if (nr != 0 || n_high != 0) $display("FAIL long2_quiet: rises=%0d high=%0d want 0/0", nr, n_high); else passes++;
    endtask

    task automatic test_burst;
        int n = 0;
        step_count = 8'd5; step_req = 1'b1;
        @(negedge sysclk);
        step_req = 1'b0;
        checks++;
        if (step_busy !== 1'b1 || cpu_clk_rise !== 1'b0) $display("FAIL burst_load: busy=%b rise=%b want 1/0", step_busy, cpu_clk_rise);
        else passes++;
        for (int c = 0; c < 60; c++) begin
            @(negedge sysclk);
            step_req = 1'b0;
            if (cpu_clk_rise) begin
                n++;
                checks++;
                if (step_busy !== (n < 5)) $display("FAIL burst_busy_rise%0d: got %b want %b", n, step_busy, n < 5);
                else passes++;
                if (n == 3) step_req = 1'b1;
            end
        end
        checks++; if (n != 5) $display("FAIL burst_rises: got %0d want 5", n); else passes++;
        wait_idle(100, 1'b1, "burst_idle");
        n = 0;
        halt = 1'b1; step_count = 8'd0; step_req = 1'b1;
        @(negedge sysclk);
        step_req = 1'b0;
        repeat (30) begin
            @(negedge sysclk);
            n += int'(cpu_clk_rise);
        end
        halt = 1'b0;
        checks++; if (n != 1) $display("FAIL burst_zero_rises: got %0d want 1", n); else passes++;
    endtask

    task automatic test_reset_mid_high;
        int n = 0;
        step_count = 8'd5; step_req = 1'b1;
        @(negedge sysclk);
        step_req = 1'b0;
        while (!cpu_clk_rise && n < 20) begin @(negedge sysclk); n++; end
        checks++; if (cpu_clk !== 1'b1) $display("FAIL midrst_high: got %b want 1", cpu_clk); else passes++;
        reset = 1'b1;
        @(negedge sysclk);
        checks++; if (cpu_clk !== 1'b0) $display("FAIL midrst_clk: got %b want 0", cpu_clk); else passes++;
        checks++; if (cpu_clk_rise !== 1'b0 || short_evt !== 1'b0 || long_evt !== 1'b0)
            $display("FAIL midrst_evts: rise=%b short=%b long=%b want 0/0/0", cpu_clk_rise, short_evt, long_evt);
        else passes++;
        checks++; if (step_busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", step_busy); else passes++;
        checks++; if (autorun !== 1'b1) $display("FAIL midrst_autorun: got %b want 1", autorun); else passes++;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_autorun();
        test_halt();
        test_power_on_override();
        test_short_press();
        test_long_press();
        test_burst();
        test_reset_mid_high();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
